// File: rtl/lcd_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_cmd_sequencer
//
// Upstream master for the LCD strobe/timing controller. It waits out the LCD
// power-up time after reset, issues the fixed HD44780 init sequence
// (38, 0C, 01, 06), then forwards user bytes one bus cycle at a time.
//
// Each bus cycle is a write strobe held until the controller acknowledges it.
// The controller acknowledges by pulling rdy low. The strobe is then released.
// The sequencer waits for rdy to return high before starting anything else.
//
// Optional feature, macro LCD_SEQ_LINE_WRAP_EN:
//   - A column counter tracks completed data bytes.
//   - After the 16th data byte the sequencer inserts 8'hC0 (move to line 2).
//   - After the 32nd it inserts 8'h80 (back to line 1) and the counter wraps.
//   - User commands 8'h01 (clear) and 8'h02 (home) zero the counter.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   rdy          controller RDY: low = cycle accepted / busy, high = idle.
//                Assumed to be synchronous to clk.
//   in_valid     user byte available
//   in_rs        1 = character (data register), 0 = command
//   in_data      user byte
//   in_ready     byte accepted on a clock edge where in_valid & in_ready
//   nCS, nWR     active-low chip select / write strobe, always move together
//   nRD          read strobe, held inactive (reads are not used)
//   rs, db       register select and data byte presented to the controller
//   init_done    high once the init sequence has finished (sticky)
//   err_timeout  one-cycle pulse when a strobe is abandoned without an ack
// -----------------------------------------------------------------------------
module lcd_cmd_sequencer #(
  parameter int PWRUP_CYCLES = 750000,
  parameter int ACK_TIMEOUT  = 16,
  parameter int STROBE_MIN   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       nCS,
  output logic       nWR,
  output logic       nRD,
  output logic       rs,
  output logic [7:0] db,
  output logic       init_done,
  output logic       err_timeout
);

  localparam int PW = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  // The counters hold the number of cycles already spent in a state.
  // Comparing against "count - 1" therefore means "this is the last cycle".
  localparam logic [PW-1:0] PWR_LAST = PW'(PWRUP_CYCLES - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(STROBE_MIN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_LOAD,
    S_IDLE,
    S_STROBE,
    S_RELEASE,
    S_WAIT_DONE
  } state_t;

  state_t        state_reg,       state_next;
  logic [PW-1:0] pwr_cnt_reg,     pwr_cnt_next;
  logic [TW-1:0] stb_cnt_reg,     stb_cnt_next;
  logic          ack_seen_reg,    ack_seen_next;
  logic [1:0]    idx_reg,         idx_next;
  logic          init_done_reg,   init_done_next;
  logic          ncs_reg,         ncs_next;
  logic          nwr_reg,         nwr_next;
  logic          rs_reg,          rs_next;
  logic [7:0]    db_reg,          db_next;
  logic          in_ready_reg,    in_ready_next;
  logic          err_timeout_reg, err_timeout_next;

`ifdef LCD_SEQ_LINE_WRAP_EN
  logic [4:0]    col_reg,         col_next;
  logic          ins_pending_reg, ins_pending_next;
  logic [7:0]    ins_byte_reg,    ins_byte_next;
  logic [5:0]    col_inc;
`endif

  // Per-cycle actions shared by several states
  logic start_strobe;   // begin a new bus cycle with the rs/db being loaded
  logic go_idle;        // return to S_IDLE and open the user handshake
  logic cycle_end;      // bus cycle finished, either completed or aborted

  function automatic logic [7:0] init_rom(input logic [1:0] i);
    case (i)
      2'd0:    init_rom = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
      2'd1:    init_rom = 8'h0C;  // display on, cursor off
      2'd2:    init_rom = 8'h01;  // clear display
      default: init_rom = 8'h06;  // entry mode: increment, no shift
    endcase
  endfunction

  always_comb begin
    state_next       = state_reg;
    pwr_cnt_next     = pwr_cnt_reg;
    stb_cnt_next     = stb_cnt_reg;
    ack_seen_next    = ack_seen_reg;
    idx_next         = idx_reg;
    init_done_next   = init_done_reg;
    ncs_next         = ncs_reg;
    nwr_next         = nwr_reg;
    rs_next          = rs_reg;
    db_next          = db_reg;
    in_ready_next    = in_ready_reg;
    err_timeout_next = 1'b0;
    start_strobe     = 1'b0;
    go_idle          = 1'b0;
    cycle_end        = 1'b0;
`ifdef LCD_SEQ_LINE_WRAP_EN
    col_next         = col_reg;
    ins_pending_next = ins_pending_reg;
    ins_byte_next    = ins_byte_reg;
    col_inc          = {1'b0, col_reg} + 6'd1;
`endif

    case (state_reg)
      S_PWRUP: begin
        if (pwr_cnt_reg == PWR_LAST) begin
          state_next = S_LOAD;
        end else begin
          pwr_cnt_next = pwr_cnt_reg + 1'b1;
        end
      end

      S_LOAD: begin
        if (!init_done_reg) begin
          rs_next      = 1'b0;
          db_next      = init_rom(idx_reg);
          start_strobe = 1'b1;
`ifdef LCD_SEQ_LINE_WRAP_EN
        end else if (ins_pending_reg) begin
          rs_next          = 1'b0;
          db_next          = ins_byte_reg;
          ins_pending_next = 1'b0;
          start_strobe     = 1'b1;
`endif
        end else begin
          go_idle = 1'b1;
        end
      end

      S_IDLE: begin
        if (in_valid && in_ready_reg) begin
          rs_next       = in_rs;
          db_next       = in_data;
          in_ready_next = 1'b0;
          start_strobe  = 1'b1;
        end
      end

      S_STROBE: begin
        stb_cnt_next  = stb_cnt_reg + 1'b1;
        ack_seen_next = ack_seen_reg | ~rdy;
        // A valid ack takes priority over the timeout.
        // Otherwise a rdy that drops on the very last cycle would be lost.
        if ((ack_seen_reg | ~rdy) && (stb_cnt_reg >= STB_LAST)) begin
          ncs_next   = 1'b1;
          nwr_next   = 1'b1;
          state_next = S_RELEASE;
        end else if (stb_cnt_reg >= TO_LAST) begin
          ncs_next         = 1'b1;
          nwr_next         = 1'b1;
          err_timeout_next = 1'b1;
          cycle_end        = 1'b1;
        end
      end

      S_RELEASE: begin
        state_next = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        // No timeout here: a Clear command can keep the LCD busy for ~1.5 ms.
        if (rdy) begin
          cycle_end = 1'b1;
        end
      end

      default: begin
        state_next = S_PWRUP;
      end
    endcase

    if (cycle_end) begin
      if (!init_done_reg) begin
        // An aborted init command still advances the index.
        // This is also true for the last one, so the init cannot loop forever.
        idx_next = idx_reg + 2'd1;
        if (idx_reg == 2'd3) begin
          init_done_next = 1'b1;
          go_idle        = 1'b1;
        end else begin
          state_next = S_LOAD;
        end
      end else begin
`ifdef LCD_SEQ_LINE_WRAP_EN
        // Only completed cycles (not timeouts) move the column counter.
        if (state_reg == S_WAIT_DONE) begin
          if (rs_reg) begin
            col_next = col_inc[4:0];  // 32 wraps to 0 in five bits
            if (col_inc == 6'd16) begin
              ins_pending_next = 1'b1;
              ins_byte_next    = 8'hC0;
            end else if (col_inc == 6'd32) begin
              ins_pending_next = 1'b1;
              ins_byte_next    = 8'h80;
            end
          end else if ((db_reg == 8'h01) || (db_reg == 8'h02)) begin
            col_next = 5'd0;
          end
        end
        if (ins_pending_next) begin
          state_next = S_LOAD;
        end else begin
          go_idle = 1'b1;
        end
`else
        go_idle = 1'b1;
`endif
      end
    end

    if (start_strobe) begin
      state_next    = S_STROBE;
      ncs_next      = 1'b0;
      nwr_next      = 1'b0;
      stb_cnt_next  = '0;
      ack_seen_next = 1'b0;
    end

    if (go_idle) begin
      state_next    = S_IDLE;
      in_ready_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_PWRUP;
      pwr_cnt_reg     <= '0;
      stb_cnt_reg     <= '0;
      ack_seen_reg    <= 1'b0;
      idx_reg         <= 2'd0;
      init_done_reg   <= 1'b0;
      ncs_reg         <= 1'b1;
      nwr_reg         <= 1'b1;
      rs_reg          <= 1'b0;
      db_reg          <= 8'h00;
      in_ready_reg    <= 1'b0;
      err_timeout_reg <= 1'b0;
`ifdef LCD_SEQ_LINE_WRAP_EN
      col_reg         <= 5'd0;
      ins_pending_reg <= 1'b0;
      ins_byte_reg    <= 8'h00;
`endif
    end else begin
      state_reg       <= state_next;
      pwr_cnt_reg     <= pwr_cnt_next;
      stb_cnt_reg     <= stb_cnt_next;
      ack_seen_reg    <= ack_seen_next;
      idx_reg         <= idx_next;
      init_done_reg   <= init_done_next;
      ncs_reg         <= ncs_next;
      nwr_reg         <= nwr_next;
      rs_reg          <= rs_next;
      db_reg          <= db_next;
      in_ready_reg    <= in_ready_next;
      err_timeout_reg <= err_timeout_next;
`ifdef LCD_SEQ_LINE_WRAP_EN
      col_reg         <= col_next;
      ins_pending_reg <= ins_pending_next;
      ins_byte_reg    <= ins_byte_next;
`endif
    end
  end

  assign nCS         = ncs_reg;
  assign nWR         = nwr_reg;
  assign nRD         = 1'b1;
  assign rs          = rs_reg;
  assign db          = db_reg;
  assign in_ready    = in_ready_reg;
  assign init_done   = init_done_reg;
  assign err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for lcd_cmd_sequencer.
//
// Structure:
//   - The driver issues user bytes and pushes the expected bus cycles into
//     exp_q, computed from a simple list model of the byte stream.
//   - The monitor detects each strobe, pops exp_q and compares rs/db.
//     It also checks the per-cycle handshake rules.
//   - A small LCD model drives rdy in response to strobes.
// -----------------------------------------------------------------------------
module tb_lcd_cmd_sequencer;

  localparam int PWRUP = 20;
  localparam int TO    = 16;
  localparam int SMIN  = 2;

  typedef struct packed {
    logic       rs;
    logic [7:0] db;
  } bus_t;

  logic       clk;
  logic       rst;
  logic       rdy;
  logic       in_valid;
  logic       in_rs;
  logic [7:0] in_data;
  logic       in_ready;
  logic       nCS;
  logic       nWR;
  logic       nRD;
  logic       rs;
  logic [7:0] db;
  logic       init_done;
  logic       err_timeout;

  lcd_cmd_sequencer #(
    .PWRUP_CYCLES(PWRUP),
    .ACK_TIMEOUT (TO),
    .STROBE_MIN  (SMIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .in_valid   (in_valid),
    .in_rs      (in_rs),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .nCS        (nCS),
    .nWR        (nWR),
    .nRD        (nRD),
    .rs         (rs),
    .db         (db),
    .init_done  (init_done),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  bus_t exp_q[$];
  int   exp_timeouts = 0;
  logic [7:0] init_bytes [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
`ifdef LCD_SEQ_LINE_WRAP_EN
  int   col_cnt = 0;
`endif

  int strobe_count      = 0;
  int strobes_since_rst = 0;
  int err_cnt           = 0;
  int last_width        = 0;
  int cyc               = 0;
  bit init_seen         = 0;
  bit rdy_dead          = 0;
  int busy              = 10;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model of the expected bus traffic for one accepted user byte
  task automatic model_push(input logic r, input logic [7:0] d, input bit will_timeout);
    exp_q.push_back({r, d});
    if (will_timeout) exp_timeouts++;
`ifdef LCD_SEQ_LINE_WRAP_EN
    if (!will_timeout) begin
      if (r) begin
        col_cnt++;
        if (col_cnt == 16) begin
          exp_q.push_back({1'b0, 8'hC0});
        end else if (col_cnt == 32) begin
          exp_q.push_back({1'b0, 8'h80});
          col_cnt = 0;
        end
      end else if (d == 8'h01 || d == 8'h02) begin
        col_cnt = 0;
      end
    end
`endif
  endtask

  task automatic push_init();
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, init_bytes[i]});
`ifdef LCD_SEQ_LINE_WRAP_EN
    col_cnt = 0;
`endif
  endtask

  // Must be called right after a negedge
  task automatic send(input logic r, input logic [7:0] d, input bit will_timeout);
    in_valid = 1'b1;
    in_rs    = r;
    in_data  = d;
    for (int i = 0; i < 1000 && in_ready !== 1'b1; i++) @(negedge clk);
    check("send_handshake", 32'(in_ready), 32'd1);
    model_push(r, d, will_timeout);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // LCD model: rdy falls 2 cycles into a strobe and rises 'busy' cycles later
  initial begin
    rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && nCS === 1'b0 && !rdy_dead) begin
        repeat (2) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (busy) @(posedge clk);
        #1 rdy = 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit   prev_ncs;
    bit   active;
    bit   released;
    int   width;
    int   proto_err;
    bus_t cur;
    prev_ncs  = 1'b1;
    active    = 1'b0;
    released  = 1'b0;
    width     = 0;
    proto_err = 0;
    cur       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ncs          = 1'b1;
        active            = 1'b0;
        strobes_since_rst = 0;
        init_seen         = 1'b0;
        continue;
      end
      if (err_timeout === 1'b1) err_cnt++;
      if (init_done === 1'b1 && !init_seen) begin
        init_seen = 1'b1;
        check("init_done_after_4th", 32'(strobes_since_rst), 32'd4);
        check("rdy_high_at_init_done", 32'(rdy), 32'd1);
        check("in_ready_after_init", 32'(in_ready), 32'd1);
      end
      if (nCS === 1'b0 && prev_ncs) begin
        strobe_count++;
        strobes_since_rst++;
        if (strobes_since_rst == 1) begin
          // PWRUP counted cycles, plus the load cycle, precede the first strobe
          check("pwrup_delay", 32'(cyc > PWRUP), 32'd1);
        end
        cur = {rs, db};
        $display("[TB] bus cycle %0d: rs=%0d db=%02h", strobe_count, rs, db);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: got rs=%0d db=%02h, expected none", rs, db);
        end else begin
          check("bus_byte", 32'({rs, db}), 32'(exp_q.pop_front()));
        end
        width     = 0;
        proto_err = 0;
        active    = 1'b1;
        released  = 1'b0;
      end
      if (active) begin
        if (nCS !== 1'b0 && !released) begin
          released   = 1'b1;
          last_width = width;
          check("strobe_min_width", 32'(width >= SMIN), 32'd1);
        end
        if (!released) width++;
        if (nCS !== nWR || nRD !== 1'b1) proto_err++;
        if ({rs, db} !== cur) proto_err++;
        if ((!released || !rdy) && in_ready !== 1'b0) proto_err++;
        if (released && rdy) begin
          active = 1'b0;
          check("cycle_protocol", 32'(proto_err), 32'd0);
        end
      end
      prev_ncs = (nCS !== 1'b0);
    end
  end

  // Driver
  initial begin
    int sc;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_rs    = 1'b0;
    in_data  = 8'h00;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_values",
          32'({nCS, nWR, nRD, rs, db, in_ready, init_done, err_timeout}),
          32'({1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'b000}));
    push_init();
    rst = 1'b0;

    // Reset while the LCD is busy with the init Clear command
    for (int i = 0; i < 2000 && strobes_since_rst < 3; i++) @(negedge clk);
    check("reach_init_clear", 32'(strobes_since_rst), 32'd3);
    for (int i = 0; i < 200 && nCS !== 1'b1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", 32'({nCS, nWR, init_done}), 32'({1'b1, 1'b1, 1'b0}));
    push_init();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 2000 && init_done !== 1'b1; i++) @(negedge clk);
    check("init_completes", 32'(init_done), 32'd1);
    @(negedge clk);

    // Single character
    send(1'b1, 8'h41, 1'b0);
    for (int i = 0; i < 200 && in_ready !== 1'b1; i++) @(negedge clk);
    check("in_ready_returns", 32'(in_ready), 32'd1);

    // Timeout: rdy never falls
    rdy_dead = 1'b1;
    send(1'b0, 8'h14, 1'b1);
    for (int i = 0; i < 100 && err_timeout !== 1'b1; i++) @(negedge clk);
    check("err_timeout_seen", 32'(err_timeout), 32'd1);
    check("in_ready_with_err", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("err_pulse_width", 32'(err_timeout), 32'd0);
    check("timeout_strobe_width", 32'(last_width), 32'(TO));
    sc = strobe_count;
    repeat (40) @(negedge clk);
    check("no_strobe_after_timeout", 32'(strobe_count), 32'(sc));
    check("err_pulse_count", 32'(err_cnt), 32'd1);
    rdy_dead = 1'b0;

    // Clear, then 17 characters (line wrap point)
    send(1'b0, 8'h01, 1'b0);
    for (int i = 0; i < 17; i++) send(1'b1, 8'(8'h61 + i), 1'b0);

    // Back-to-back random bytes against a slow LCD
    busy = 200;
    for (int i = 0; i < 20; i++) begin
      logic       r;
      logic [7:0] d;
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      send(r, d, 1'b0);
    end

    for (int i = 0; i < 20000 && (exp_q.size() != 0 || in_ready !== 1'b1); i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("err_total", 32'(err_cnt), 32'(exp_timeouts));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
